// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller: opcode constants, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_ADDSUB = 3'b001;
  localparam logic [2:0] OP_NOT    = 3'b010;
  localparam logic [2:0] OP_AND    = 3'b011;
  localparam logic [2:0] OP_OR     = 3'b100;
  localparam logic [2:0] OP_XOR    = 3'b101;
  localparam logic [2:0] OP_LT     = 3'b110;
  localparam logic [2:0] OP_EQ     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_ctrl_rf.sv
// 4x4-bit register file: two combinational read ports, one synchronous write port,
// asynchronous reset of every entry to RF_RESET.
module alu_ctrl_rf #(
  parameter logic [3:0] RF_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [3:0] wdata,
  input  logic [1:0] raddr_a,
  output logic [3:0] rdata_a,
  input  logic [1:0] raddr_b,
  output logic [3:0] rdata_b
);

  logic [3:0] mem_r [4];

  // Storage array with single write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mem_r[i] <= RF_RESET;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_r[raddr_a];
  assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/alu_ctrl.sv
// Sequencer in front of an external 4-bit ALU: accepts a command, drives the ALU for one
// cycle, writes the result back and presents it. Optional load-immediate: ALU_CTRL_LOADI_EN.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter logic [3:0] RF_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_sub,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs1,
  input  logic [1:0] cmd_rs2,
  input  logic       cmd_load,
  input  logic [3:0] cmd_imm,
  output logic [2:0] alu_op,
  output logic       alu_c,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  input  logic [3:0] alu_s,
  input  logic       alu_cout,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic [2:0] rsp_flags
);

  state_t     state_r, state_s;
  logic       cmd_ready_r, rsp_valid_r;
  logic [2:0] alu_op_r;
  logic       alu_c_r;
  logic [3:0] alu_x_r, alu_y_r;
  logic [1:0] rd_r;
  logic [3:0] rsp_data_r;
  logic [2:0] flags_r;
  logic [3:0] rs1_val_s, rs2_val_s, wr_data_s, exec_imm_s;
  logic       accept_s, finish_s, cmd_is_load_s, exec_load_s;

  assign accept_s = (state_r == ST_IDLE) && cmd_valid;
  assign finish_s = (state_r == ST_EXEC);

`ifdef ALU_CTRL_LOADI_EN
  logic       load_r;
  logic [3:0] imm_r;

  // Immediate path captured alongside the command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_r <= 1'b0;
      imm_r  <= 4'h0;
    end else if (accept_s) begin
      load_r <= cmd_load;
      imm_r  <= cmd_imm;
    end
  end

  assign cmd_is_load_s = cmd_load;
  assign exec_load_s   = load_r;
  assign exec_imm_s    = imm_r;
`else
  logic unused_loadi_s;
  assign unused_loadi_s = ^{cmd_load, cmd_imm};
  assign cmd_is_load_s  = 1'b0;
  assign exec_load_s    = 1'b0;
  assign exec_imm_s     = 4'h0;
`endif

  alu_ctrl_rf #(.RF_RESET(RF_RESET)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (finish_s),
    .waddr   (rd_r),
    .wdata   (wr_data_s),
    .raddr_a (cmd_rs1),
    .rdata_a (rs1_val_s),
    .raddr_b (cmd_rs2),
    .rdata_b (rs2_val_s)
  );

  // Write-back value: immediate for a load, ALU sum otherwise
  always_comb begin
    wr_data_s = alu_s;
    if (exec_load_s) begin
      wr_data_s = exec_imm_s;
    end else begin
      wr_data_s = alu_s;
    end
  end

  // FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) state_s = ST_EXEC;
        else           state_s = ST_IDLE;
      end
      ST_EXEC: state_s = ST_EXEC == state_r ? ST_RESP : ST_IDLE;
      ST_RESP: begin
        if (rsp_ready) state_s = ST_IDLE;
        else           state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state and handshake outputs, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      rsp_valid_r <= (state_s == ST_RESP);
    end
  end

  // Command capture, ALU drive for the EXEC cycle, response and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_r   <= 3'b000;
      alu_c_r    <= 1'b0;
      alu_x_r    <= 4'h0;
      alu_y_r    <= 4'h0;
      rd_r       <= 2'b00;
      rsp_data_r <= 4'h0;
      flags_r    <= 3'b000;
    end else if (accept_s) begin
      rd_r <= cmd_rd;
      if (cmd_is_load_s) begin
        alu_op_r <= 3'b000;
        alu_c_r  <= 1'b0;
        alu_x_r  <= 4'h0;
        alu_y_r  <= 4'h0;
      end else begin
        alu_op_r <= cmd_op;
        alu_c_r  <= cmd_sub;
        alu_x_r  <= rs1_val_s;
        alu_y_r  <= rs2_val_s;
      end
    end else if (finish_s) begin
      alu_op_r   <= 3'b000;
      alu_c_r    <= 1'b0;
      alu_x_r    <= 4'h0;
      alu_y_r    <= 4'h0;
      rsp_data_r <= wr_data_s;
      if (!exec_load_s) begin
        flags_r[FLAG_C] <= alu_cout;
        flags_r[FLAG_Z] <= alu_zero;
        flags_r[FLAG_V] <= alu_ovf;
      end
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_flags = flags_r;
  assign alu_op    = alu_op_r;
  assign alu_c     = alu_c_r;
  assign alu_x     = alu_x_r;
  assign alu_y     = alu_y_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: stand-in ALU, transaction-level reference model with a
// per-cycle compare, directed literal checks and randomized commands.
`timescale 1ns/1ps
module tb_alu_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid, cmd_ready, cmd_sub, cmd_load;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [3:0] cmd_imm;
  logic [2:0] alu_op;
  logic       alu_c, alu_cout, alu_zero, alu_ovf;
  logic [3:0] alu_x, alu_y, alu_s;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data;
  logic [2:0] rsp_flags;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ALU_CTRL_LOADI_EN
  localparam bit LOADI = 1'b1;
`else
  localparam bit LOADI = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_ctrl #(.RF_RESET(4'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sub(cmd_sub),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_load(cmd_load), .cmd_imm(cmd_imm),
    .alu_op(alu_op), .alu_c(alu_c), .alu_x(alu_x), .alu_y(alu_y),
    .alu_s(alu_s), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags)
  );

  // Stand-in ALU returning {s, cout, zero, ovf}; ovf is two's-complement overflow of add/sub,
  // zero of the compare ops reflects x-y.
  function automatic logic [6:0] alu_fn(input logic [2:0] op, input logic c,
                                        input logic [3:0] x, input logic [3:0] y);
    logic [3:0] yy, s, diff;
    logic [4:0] sum;
    logic co, z, v;
    yy   = (op == OP_ADDSUB && c) ? ~y : y;
    sum  = {1'b0, x} + {1'b0, yy} + {4'h0, c};
    diff = x - y;
    co = 1'b0;
    v  = 1'b0;
    case (op)
      OP_ADD, OP_ADDSUB: begin
        s  = sum[3:0];
        co = sum[4];
        v  = (x[3] == yy[3]) && (s[3] != x[3]);
      end
      OP_NOT: s = ~x;
      OP_AND: s = x & y;
      OP_OR:  s = x | y;
      OP_XOR: s = x ^ y;
      OP_LT:  s = (x < y) ? 4'h1 : 4'h0;
      default: s = (x == y) ? 4'h1 : 4'h0;
    endcase
    z = (op == OP_LT || op == OP_EQ) ? (diff == 4'h0) : (s == 4'h0);
    return {s, co, z, v};
  endfunction

  assign {alu_s, alu_cout, alu_zero, alu_ovf} = alu_fn(alu_op, alu_c, alu_x, alu_y);

  // Reference model: phase 0 waiting, 1 executing, 2 responding
  int         m_phase;
  logic [3:0] m_rf [4];
  logic [2:0] m_op;
  logic       m_sub, m_ld;
  logic [1:0] m_rd;
  logic [3:0] m_x, m_y, m_imm, m_data;
  logic [2:0] m_flags;
  wire  [6:0] m_res = alu_fn(m_op, m_sub, m_x, m_y);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      for (int i = 0; i < 4; i++) m_rf[i] <= 4'h0;
      m_op <= 3'b000; m_sub <= 1'b0; m_ld <= 1'b0; m_rd <= 2'b00;
      m_x <= 4'h0; m_y <= 4'h0; m_imm <= 4'h0; m_data <= 4'h0; m_flags <= 3'b000;
    end else if (m_phase == 0) begin
      if (cmd_valid) begin
        m_phase <= 1;
        m_op <= cmd_op; m_sub <= cmd_sub; m_rd <= cmd_rd;
        m_x <= m_rf[cmd_rs1]; m_y <= m_rf[cmd_rs2];
        m_ld <= LOADI && cmd_load; m_imm <= cmd_imm;
      end
    end else if (m_phase == 1) begin
      m_phase <= 2;
      if (m_ld) begin
        m_rf[m_rd] <= m_imm;
        m_data     <= m_imm;
      end else begin
        m_rf[m_rd] <= m_res[6:3];
        m_data     <= m_res[6:3];
        m_flags    <= m_res[2:0];
      end
    end else if (rsp_ready) begin
      m_phase <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("handshake", {30'd0, cmd_ready, rsp_valid}, {30'd0, m_phase == 0, m_phase == 2});
    chk("response", {25'd0, rsp_data, rsp_flags}, {25'd0, m_data, m_flags});
    if (m_phase == 1 && !m_ld)
      chk("alu_drive", {20'd0, alu_op, alu_c, alu_x, alu_y}, {20'd0, m_op, m_sub, m_x, m_y});
    else
      chk("alu_drive", {20'd0, alu_op, alu_c, alu_x, alu_y}, 32'd0);
  end

  task automatic scramble();
    cmd_op  = 3'($urandom);
    cmd_sub = 1'($urandom);
    cmd_rd  = 2'($urandom);
    cmd_rs1 = 2'($urandom);
    cmd_rs2 = 2'($urandom);
    cmd_load = 1'($urandom);
    cmd_imm = 4'($urandom);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic sub, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic ld,
                         input logic [3:0] imm, input int hold, input bit pend,
                         output logic [3:0] d, output logic [2:0] f);
    int n;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_op = op; cmd_sub = sub; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_load = ld; cmd_imm = imm; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    scramble();
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 2);
    d = rsp_data;
    f = rsp_flags;
    if (pend) cmd_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold", {25'd0, cmd_ready, rsp_valid, rsp_data, rsp_flags}, {25'd0, 1'b0, 1'b1, d, f});
    end
    rsp_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    logic [2:0] f;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    scramble();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {23'd0, cmd_ready, rsp_valid, rsp_data, rsp_flags, alu_x},
        {23'd0, 1'b1, 1'b0, 4'h0, 3'b000, 4'h0});
    #2 rst_n = 1'b1;

    // Build r1=3, r2=5 from the all-zero register file
    run_cmd(OP_NOT,    1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 4'h0, 0, 1'b0, d, f); chk("not0", d, 4'hF);
    run_cmd(OP_ADDSUB, 1'b1, 2'd2, 2'd0, 2'd1, 1'b0, 4'h0, 0, 1'b0, d, f); chk("0_minus_F", d, 4'h1);
    run_cmd(OP_ADD,    1'b0, 2'd3, 2'd2, 2'd2, 1'b0, 4'h0, 0, 1'b0, d, f); chk("1p1", d, 4'h2);
    run_cmd(OP_ADD,    1'b0, 2'd1, 2'd3, 2'd2, 1'b0, 4'h0, 0, 1'b0, d, f); chk("2p1", d, 4'h3);
    run_cmd(OP_ADD,    1'b0, 2'd2, 2'd1, 2'd3, 1'b0, 4'h0, 0, 1'b0, d, f); chk("3p2", d, 4'h5);
    run_cmd(OP_EQ,     1'b1, 2'd3, 2'd2, 2'd2, 1'b0, 4'h0, 0, 1'b0, d, f);
    chk("eq_5_5", {d, f[FLAG_Z]}, {4'h1, 1'b1});
    run_cmd(OP_ADD,    1'b0, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 0, 1'b0, d, f);
    chk("add_3_5", {d, f[FLAG_C], f[FLAG_Z]}, {4'h8, 1'b0, 1'b0});
    // Held response with a pending command that must wait for the release
    run_cmd(OP_ADDSUB, 1'b1, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 5, 1'b1, d, f);
    chk("sub_3_5", {d, f[FLAG_C], f[FLAG_V]}, {4'hE, 1'b0, 1'b0});
    run_cmd(OP_NOT,    1'b0, 2'd2, 2'd3, 2'd3, 1'b0, 4'h0, 0, 1'b0, d, f); chk("notE", d, 4'h1);
    run_cmd(OP_ADD,    1'b0, 2'd1, 2'd1, 2'd1, 1'b0, 4'h0, 0, 1'b0, d, f); chk("3p3", d, 4'h6);
    run_cmd(OP_ADD,    1'b0, 2'd3, 2'd2, 2'd2, 1'b0, 4'h0, 0, 1'b0, d, f); chk("1p1b", d, 4'h2);
    run_cmd(OP_LT,     1'b0, 2'd3, 2'd3, 2'd1, 1'b0, 4'h0, 0, 1'b0, d, f); chk("lt_2_6", d, 4'h1);
    run_cmd(OP_ADD,    1'b0, 2'd1, 2'd1, 2'd2, 1'b0, 4'h0, 0, 1'b0, d, f); chk("6p1", d, 4'h7);
    run_cmd(OP_ADD,    1'b0, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 0, 1'b0, d, f);
    chk("add_7_1", {d, f[FLAG_V]}, {4'h8, 1'b1});
    run_cmd(OP_ADD,    1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 4'hA, 0, 1'b0, d, f);
`ifdef ALU_CTRL_LOADI_EN
    chk("loadi", {d, f[FLAG_V]}, {4'hA, 1'b1});
    run_cmd(OP_OR, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 4'h0, 0, 1'b0, d, f); chk("r0_after_load", d, 4'hA);
`else
    chk("load_as_alu", {d, f[FLAG_V]}, {4'h8, 1'b1});
    run_cmd(OP_OR, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 4'h0, 0, 1'b0, d, f); chk("r0_after_load", d, 4'h8);
`endif

    // Reset while an add into r2 is executing
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_op = OP_ADD; cmd_sub = 1'b0; cmd_rd = 2'd2; cmd_rs1 = 2'd1; cmd_rs2 = 2'd1;
    cmd_load = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("in_exec", {30'd0, cmd_ready, rsp_valid}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {19'd0, cmd_ready, rsp_valid, rsp_data, rsp_flags, alu_x},
           {19'd0, 1'b1, 1'b0, 4'h0, 3'b000, 4'h0});
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_cmd(OP_OR, 1'b0, 2'd1, 2'd2, 2'd2, 1'b0, 4'h0, 0, 1'b0, d, f); chk("r2_reset", d, 4'h0);

    for (int i = 0; i < 60; i++) begin
      run_cmd(3'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
              1'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'($urandom), d, f);
    end

    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
